// File: rtl/stream_demux_pkg.sv
// Shared types and constants for the 1-to-N stream demultiplexer.
// Provides the holding-stage state enum, select-width helper and counter width.
package stream_demux_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } state_e;

  localparam int ERRCNT_W = 8;

  // Select width: at least one bit, even for degenerate N.
  function automatic int calc_sw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_demux_1ton_sel_decoder.sv
// Select decoder: SW-bit channel index to N-bit onehot plus out-of-range flag.
// Ports: sel_i (index), onehot_o (N-bit onehot, 0 when out of range), oor_o.
module sel_decoder #(
  parameter int N  = 4,
  parameter int SW = 2
) (
  input  logic [SW-1:0] sel_i,
  output logic [N-1:0]  onehot_o,
  output logic          oor_o
);

  always_comb begin
    onehot_o = '0;
    oor_o    = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (sel_i == SW'(i)) begin
        onehot_o[i] = 1'b1;
        oor_o       = 1'b0;
      end
    end
  end

endmodule

// File: rtl/stream_demux_1ton.sv
// Registered 1-to-N stream demux with broadcast; one holding stage, 1-cycle latency.
// Ports: CLK, RST_N (sync, active-low); IN_DATA/IN_VALID/IN_READY, SEL, BCAST in;
//   OUT_DATA shared, OUT_VALID/OUT_READY per channel; ERR drop pulse.
//   Optional ERR_CNT (saturating drop counter) when STREAM_DEMUX_ERRCNT_EN is defined.
module stream_demux_1ton
  import stream_demux_pkg::*;
#(
  parameter  int W  = 8,
  parameter  int N  = 4,
  localparam int SW = calc_sw(N)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [W-1:0]  IN_DATA,
  input  logic          IN_VALID,
  output logic          IN_READY,
  input  logic [SW-1:0] SEL,
  input  logic          BCAST,
  output logic [W-1:0]  OUT_DATA,
  output logic [N-1:0]  OUT_VALID,
  input  logic [N-1:0]  OUT_READY,
  output logic          ERR
`ifdef STREAM_DEMUX_ERRCNT_EN
  ,
  output logic [ERRCNT_W-1:0] ERR_CNT
`endif
);

  state_e         state_q, state_d;
  logic [N-1:0]   mask_q, mask_d;
  logic [W-1:0]   data_q, data_d;
  logic           err_q, err_d;

  logic [N-1:0]   sel_oh;
  logic           sel_oor;
  logic [N-1:0]   remain;
  logic           drain;
  logic           accept;
  logic           acc_bc;
  logic           acc_uc;
  logic           acc_drop;

  sel_decoder #(
    .N  (N),
    .SW (SW)
  ) u_dec (
    .sel_i    (SEL),
    .onehot_o (sel_oh),
    .oor_o    (sel_oor)
  );

  // Bits still waiting after this cycle's handshakes.
  assign remain = mask_q & ~OUT_READY;
  assign drain  = (state_q == HOLD) && (remain == '0);

  assign IN_READY = RST_N & ((state_q == EMPTY) | drain);
  assign accept   = IN_VALID & IN_READY;

  assign acc_bc   = accept & BCAST;
  assign acc_uc   = accept & ~BCAST & ~sel_oor;
  assign acc_drop = accept & ~BCAST & sel_oor;

  always_comb begin
    mask_d  = remain;
    data_d  = data_q;
    err_d   = 1'b0;
    state_d = state_q;

    unique case (1'b1)
      acc_bc: begin
        mask_d = '1;
        data_d = IN_DATA;
      end
      acc_uc: begin
        mask_d = sel_oh;
        data_d = IN_DATA;
      end
      // Dropped item: remain is already 0 here (EMPTY or draining).
      acc_drop: begin
        err_d = 1'b1;
      end
      default: begin
      end
    endcase

    case (state_q)
      EMPTY:   state_d = (mask_d != '0) ? HOLD : EMPTY;
      HOLD:    state_d = (mask_d != '0) ? HOLD : EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= EMPTY;
      mask_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign OUT_DATA  = data_q;
  assign OUT_VALID = (state_q == HOLD) ? mask_q : '0;
  assign ERR       = err_q;

`ifdef STREAM_DEMUX_ERRCNT_EN
  logic [ERRCNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (err_q && (cnt_q != {ERRCNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ERR_CNT = cnt_q;
`endif

endmodule

// File: tb/tb_stream_demux_1ton.sv
// Bench for stream_demux_1ton: N=4 scoreboarded instance plus N=5 instance
// for out-of-range select handling and the optional drop counter.
module tb_stream_demux_1ton;

  logic       clk = 1'b0;
  logic       rst_n;

  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] sel;
  logic       bcast;
  logic [7:0] out_data;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic       err;

  logic [7:0] d5_in;
  logic       v5_in;
  logic       r5_in;
  logic [2:0] s5;
  logic       b5;
  logic [7:0] d5_out;
  logic [4:0] v5_out;
  logic [4:0] r5_out;
  logic       e5;

`ifdef STREAM_DEMUX_ERRCNT_EN
  logic [7:0] cnt4;
  logic [7:0] cnt5;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    int         ch;
    logic [7:0] d;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  stream_demux_1ton #(.W(8), .N(4)) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .IN_DATA   (in_data),
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
    .SEL       (sel),
    .BCAST     (bcast),
    .OUT_DATA  (out_data),
    .OUT_VALID (out_valid),
    .OUT_READY (out_ready),
    .ERR       (err)
`ifdef STREAM_DEMUX_ERRCNT_EN
    ,
    .ERR_CNT   (cnt4)
`endif
  );

  stream_demux_1ton #(.W(8), .N(5)) dut5 (
    .CLK       (clk),
    .RST_N     (rst_n),
    .IN_DATA   (d5_in),
    .IN_VALID  (v5_in),
    .IN_READY  (r5_in),
    .SEL       (s5),
    .BCAST     (b5),
    .OUT_DATA  (d5_out),
    .OUT_VALID (v5_out),
    .OUT_READY (r5_out),
    .ERR       (e5)
`ifdef STREAM_DEMUX_ERRCNT_EN
    ,
    .ERR_CNT   (cnt5)
`endif
  );

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Input side: on each accepted item, push the deliveries it must produce.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      if (bcast) begin
        for (int c = 0; c < 4; c++) sb.push_back('{c, in_data});
      end else begin
        sb.push_back('{int'(sel), in_data});
      end
    end
  end

  // Output side: every handshake must match the oldest pending entry for that channel.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int c = 0; c < 4; c++) begin
        if (out_valid[c] && out_ready[c]) begin
          int idx;
          idx = -1;
          for (int k = 0; k < sb.size(); k++) begin
            if (idx < 0 && sb[k].ch == c) idx = k;
          end
          if (idx < 0) begin
            check($sformatf("sb_unexpected_ch%0d", c), 32'(out_data), 32'hFFFF_FFFF);
          end else begin
            check($sformatf("sb_data_ch%0d", c), 32'(out_data), 32'(sb[idx].d));
            sb.delete(idx);
          end
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    in_data   = 8'hFF;
    in_valid  = 1'b1;
    sel       = 2'd0;
    bcast     = 1'b0;
    out_ready = 4'b0000;
    d5_in     = 8'h00;
    v5_in     = 1'b0;
    s5        = 3'd0;
    b5        = 1'b0;
    r5_out    = 5'b00000;

    // 1. reset
    step();
    step();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst5_out_valid", 32'(v5_out), 32'd0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    step();

    // 2. unicast with stall
    in_data  = 8'hA5;
    sel      = 2'd2;
    in_valid = 1'b1;
    #1;
    check("uc_ready_empty", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("uc_stall_valid", 32'(out_valid), 32'b0100);
      check("uc_stall_data", 32'(out_data), 32'hA5);
      check("uc_stall_ready", 32'(in_ready), 32'd0);
      if (i < 2) step();
    end
    out_ready = 4'b0100;
    #1;
    check("uc_ready_drain", 32'(in_ready), 32'd1);
    step();
    check("uc_valid_after", 32'(out_valid), 32'd0);

    // 3. back-to-back
    out_ready = 4'b1111;
    for (int i = 0; i < 16; i++) begin
      in_data  = 8'(i + 1);
      sel      = 2'(i % 4);
      in_valid = 1'b1;
      #1;
      check("b2b_ready", 32'(in_ready), 32'd1);
      if (i == 0) begin
        check("b2b_valid0", 32'(out_valid), 32'd0);
      end else begin
        check("b2b_valid", 32'(out_valid), 32'(1 << ((i - 1) % 4)));
        check("b2b_data", 32'(out_data), 32'(i));
      end
      step();
    end
    in_valid = 1'b0;
    #1;
    check("b2b_last_valid", 32'(out_valid), 32'b1000);
    check("b2b_last_data", 32'(out_data), 32'h10);
    step();
    check("b2b_idle", 32'(out_valid), 32'd0);

    // 4. broadcast with staggered readies
    out_ready = 4'b0000;
    in_data   = 8'h3C;
    bcast     = 1'b1;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    bcast    = 1'b0;
    #1;
    check("bc_v1111", 32'(out_valid), 32'b1111);
    check("bc_data", 32'(out_data), 32'h3C);
    out_ready = 4'b0001;
    #1;
    check("bc_ir_ch0", 32'(in_ready), 32'd0);
    step();
    check("bc_v1110", 32'(out_valid), 32'b1110);
    out_ready = 4'b1001;
    #1;
    check("bc_ir_ch3", 32'(in_ready), 32'd0);
    step();
    check("bc_v0110", 32'(out_valid), 32'b0110);
    out_ready = 4'b1011;
    #1;
    check("bc_ir_ch1", 32'(in_ready), 32'd0);
    step();
    check("bc_v0100", 32'(out_valid), 32'b0100);
    out_ready = 4'b1111;
    #1;
    check("bc_ir_ch2", 32'(in_ready), 32'd1);
    step();
    check("bc_v0000", 32'(out_valid), 32'd0);

    // 5. out of range on the N=5 instance
    d5_in = 8'h11;
    s5    = 3'd4;
    v5_in = 1'b1;
    step();
    check("oor_hold_valid", 32'(v5_out), 32'b10000);
    check("oor_hold_err", 32'(e5), 32'd0);
    d5_in  = 8'h22;
    s5     = 3'd6;
    r5_out = 5'b10000;
    #1;
    check("oor_ir_drain", 32'(r5_in), 32'd1);
    step();
    v5_in = 1'b0;
    #1;
    check("oor_err", 32'(e5), 32'd1);
    check("oor_valid", 32'(v5_out), 32'd0);
    check("oor_empty_ready", 32'(r5_in), 32'd1);
    check("oor_data_kept", 32'(d5_out), 32'h11);
    step();
    check("oor_err_once", 32'(e5), 32'd0);
    s5    = 3'd5;
    v5_in = 1'b1;
    step();
    v5_in = 1'b0;
    check("oor_empty_err", 32'(e5), 32'd1);
    check("oor_empty_valid", 32'(v5_out), 32'd0);
    step();
    check("oor_empty_err_off", 32'(e5), 32'd0);
`ifdef STREAM_DEMUX_ERRCNT_EN
    check("cnt_two", 32'(cnt5), 32'd2);
    s5    = 3'd7;
    v5_in = 1'b1;
    for (int i = 0; i < 300; i++) step();
    v5_in = 1'b0;
    step();
    step();
    check("cnt_sat", 32'(cnt5), 32'd255);
    check("cnt4_zero", 32'(cnt4), 32'd0);
`endif

    // 6. reset mid-broadcast
    out_ready = 4'b0000;
    in_data   = 8'h77;
    bcast     = 1'b1;
    in_valid  = 1'b1;
    step();
    in_valid  = 1'b0;
    bcast     = 1'b0;
    out_ready = 4'b0101;
    step();
    check("mid_v1010", 32'(out_valid), 32'b1010);
    out_ready = 4'b0000;
    rst_n     = 1'b0;
    #1;
    check("mid_rst_ir", 32'(in_ready), 32'd0);
    step();
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    // The held broadcast was discarded by reset; drop its pending deliveries.
    sb.delete();
    rst_n    = 1'b1;
    in_data  = 8'h5A;
    sel      = 2'd1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("post_rst_valid", 32'(out_valid), 32'b0010);
    check("post_rst_data", 32'(out_data), 32'h5A);
    out_ready = 4'b0010;
    step();
    check("post_rst_done", 32'(out_valid), 32'd0);
    step();

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
